// File: rtl/lms_dsp_pkg.sv
// Shared definitions for the lms_dsp receive path: sample width, error bit
// positions on the FIR sink stream, and the I/Q pairing FSM states.
package lms_dsp_pkg;

  localparam int SAMPLE_W     = 12;
  localparam int ERR_W        = 2;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_SAT      = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    HAVE_I = 1'b1
  } pair_state_t;

endpackage

// File: rtl/lms_rx_iq_formatter_if.sv
// Sample-in / pair-out bus of the RX I/Q formatter. The master side is the
// LMS7 RX interface plus the FIR sink it feeds; the slave side is the formatter.
interface lms_rx_iq_formatter_if
  import lms_dsp_pkg::*;
#(
  parameter int W = SAMPLE_W
);

  logic [W-1:0]     diq_data;
  logic             diq_iqsel;
  logic             diq_valid;
  logic [2*W-1:0]   src_data;
  logic             src_valid;
  logic [ERR_W-1:0] src_error;

  modport master (
    output diq_data, diq_iqsel, diq_valid,
    input  src_data, src_valid, src_error
  );

  modport slave (
    input  diq_data, diq_iqsel, diq_valid,
    output src_data, src_valid, src_error
  );

endinterface

// File: rtl/lms_rx_dc_remover.sv
// One channel of DC removal: a leaky integrator tracks the mean with time
// constant 2^K pairs, and the registered sample minus that estimate is
// saturated back to W bits. Stage 1 is registered here; the subtract/saturate
// result is combinational so the caller registers it as stage 2.
// The reset port is active-low and asynchronous, like the rest of the path.
module lms_rx_dc_remover
  import lms_dsp_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter int K = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] x,
  input  logic                x_valid,
  output logic signed [W-1:0] y,
  output logic                sat
);

  localparam int AW = W + K;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sum;
  logic signed [W-1:0]  dc_now;
  logic signed [W-1:0]  x_s1;
  logic signed [W-1:0]  dc_s1;
  logic                 v_s1;
  logic signed [W:0]    diff;
  logic                 clip;

  // DC estimate is the accumulator's top W bits; the leaky update stays
  // inside AW bits for any W-bit input, so modular AW-bit math is exact.
  always_comb begin
    dc_now  = acc[AW-1:K];
    acc_sum = acc + $signed({{K{x[W-1]}}, x}) - $signed({{K{dc_now[W-1]}}, dc_now});
  end

  // Stage 1: capture the sample with the estimate it must be corrected by,
  // and advance (or clear, when bypassed) the integrator once per pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      x_s1  <= '0;
      dc_s1 <= '0;
      v_s1  <= 1'b0;
    end else begin
      v_s1 <= x_valid;
      if (x_valid) begin
        x_s1 <= x;
        if (en) begin
          acc   <= acc_sum;
          dc_s1 <= dc_now;
        end else begin
          acc   <= '0;
          dc_s1 <= '0;
        end
      end
    end
  end

  // Subtract with one guard bit and clamp to the W-bit two's complement range.
  always_comb begin
    diff = {x_s1[W-1], x_s1} - {dc_s1[W-1], dc_s1};
    clip = diff[W] ^ diff[W-1];
    if (!clip) begin
      y = diff[W-1:0];
    end else if (diff[W]) begin
      y = {1'b1, {(W-1){1'b0}}};
    end else begin
      y = {1'b0, {(W-1){1'b1}}};
    end
    sat = v_s1 & clip;
  end

endmodule

// File: rtl/lms_rx_iq_formatter.sv
// RX front end: pairs interleaved I/Q samples, optionally removes DC per
// channel, decimates by cfg_decim_m1+1 and drives the 24-bit FIR sink stream
// with sticky misalignment / saturation flags. Q-in to src_valid is 2 cycles.
module lms_rx_iq_formatter
  import lms_dsp_pkg::pair_state_t, lms_dsp_pkg::IDLE, lms_dsp_pkg::HAVE_I,
         lms_dsp_pkg::ERR_MISALIGN, lms_dsp_pkg::ERR_SAT;
#(
  parameter int SAMPLE_W = 12,
  parameter int DC_SHIFT = 10
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  lms_rx_iq_formatter_if.slave  iq,
  input  logic                  cfg_dc_en,
  input  logic [3:0]            cfg_decim_m1
);

  localparam int PAIR_W = 2 * SAMPLE_W;

  pair_state_t                state;
  pair_state_t                state_next;
  logic                       store_i;
  logic                       pair_done;
  logic                       misalign_evt;
  logic signed [SAMPLE_W-1:0] i_hold;

  logic [3:0]                 dcnt;
  logic [3:0]                 dcnt_eff;
  logic [3:0]                 dcnt_next;
  logic                       keep_now;
  logic                       keep_s1;

  logic signed [SAMPLE_W-1:0] y_i;
  logic signed [SAMPLE_W-1:0] y_q;
  logic                       sat_i;
  logic                       sat_q;

  logic [1:0]                 err_evt;
  logic [1:0]                 sticky;
  logic [PAIR_W-1:0]          src_data_r;
  logic                       src_valid_r;
  logic [1:0]                 src_error_r;

  // Pairing FSM state register; reset drops any half-built pair.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Any I leads to HAVE_I (a repeated I replaces the held one), any Q back to IDLE.
  always_comb begin
    state_next = state;
    if (iq.diq_valid) begin
      state_next = iq.diq_iqsel ? IDLE : HAVE_I;
    end
  end

  // Pairing actions: latch I, complete a pair, or flag a sample out of order.
  always_comb begin
    store_i      = iq.diq_valid & ~iq.diq_iqsel;
    pair_done    = iq.diq_valid &  iq.diq_iqsel & (state == HAVE_I);
    misalign_evt = iq.diq_valid & (iq.diq_iqsel ? (state == IDLE) : (state == HAVE_I));
  end

  // Hold the most recent I until its Q shows up.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      i_hold <= '0;
    end else if (store_i) begin
      i_hold <= iq.diq_data;
    end
  end

  lms_rx_dc_remover #(
    .W (SAMPLE_W),
    .K (DC_SHIFT)
  ) u_dc_i (
    .clk     (clk_clk),
    .reset   (reset_reset_n),
    .en      (cfg_dc_en),
    .x       (i_hold),
    .x_valid (pair_done),
    .y       (y_i),
    .sat     (sat_i)
  );

  lms_rx_dc_remover #(
    .W (SAMPLE_W),
    .K (DC_SHIFT)
  ) u_dc_q (
    .clk     (clk_clk),
    .reset   (reset_reset_n),
    .en      (cfg_dc_en),
    .x       ($signed(iq.diq_data)),
    .x_valid (pair_done),
    .y       (y_q),
    .sat     (sat_q)
  );

  // A ratio lowered below the running count restarts the count on this pair.
  always_comb begin
    dcnt_eff  = (dcnt > cfg_decim_m1) ? 4'd0 : dcnt;
    keep_now  = (dcnt_eff == 4'd0);
    dcnt_next = (dcnt_eff == cfg_decim_m1) ? 4'd0 : dcnt_eff + 4'd1;
  end

  // Decimation counter advances per completed pair; keep_s1 travels with stage 1.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dcnt    <= '0;
      keep_s1 <= 1'b0;
    end else begin
      keep_s1 <= pair_done & keep_now;
      if (pair_done) begin
        dcnt <= dcnt_next;
      end
    end
  end

  // Error events raised this cycle, from the pairing logic or either channel.
  always_comb begin
    err_evt               = '0;
    err_evt[ERR_MISALIGN] = misalign_evt;
    err_evt[ERR_SAT]      = sat_i | sat_q;
  end

  // Stage 2 output: an output beat reports flags gathered before it and
  // restarts collection with this cycle's events.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      src_data_r  <= '0;
      src_valid_r <= 1'b0;
      src_error_r <= '0;
      sticky      <= '0;
    end else begin
      src_valid_r <= keep_s1;
      if (keep_s1) begin
        src_data_r  <= {y_i, y_q};
        src_error_r <= sticky;
        sticky      <= err_evt;
      end else begin
        sticky      <= sticky | err_evt;
      end
    end
  end

  assign iq.src_data  = src_data_r;
  assign iq.src_valid = src_valid_r;
  assign iq.src_error = src_error_r;

endmodule

// File: tb/tb_lms_rx_iq_formatter.sv
// Directed bench for lms_rx_iq_formatter: table of plain pairs, then
// hand-written sequences for misalignment, decimation, DC removal and reset.
`timescale 1ns/1ps
module tb_lms_rx_iq_formatter;
  import lms_dsp_pkg::*;

  typedef struct {
    logic [11:0] i;
    logic [11:0] q;
    logic [23:0] exp_data;
  } pair_vec_t;

  typedef struct {
    int unsigned cyc;
    logic [23:0] data;
    logic [1:0]  err;
  } out_rec_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        cfg_dc_en;
  logic [3:0]  cfg_decim_m1;
  int unsigned cyc = 0;
  int          passes = 0;
  int          total = 0;
  out_rec_t    outq[$];

  lms_rx_iq_formatter_if #(.W(12)) bus ();

  lms_rx_iq_formatter #(
    .SAMPLE_W (12),
    .DC_SHIFT (10)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .iq            (bus),
    .cfg_dc_en     (cfg_dc_en),
    .cfg_decim_m1  (cfg_decim_m1)
  );

  // 100 MHz clock
  always #5 clk_clk = ~clk_clk;

  // free-running cycle index used for latency measurements
  always @(posedge clk_clk) cyc <= cyc + 1;

  // capture every output beat away from the active edge
  always @(negedge clk_clk) begin
    if (bus.src_valid === 1'b1) outq.push_back('{cyc, bus.src_data, bus.src_error});
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(logic sel, logic [11:0] d);
    bus.diq_valid = 1'b1;
    bus.diq_iqsel = sel;
    bus.diq_data  = d;
    @(posedge clk_clk);
    #1;
    bus.diq_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic send_pair(logic [11:0] i, logic [11:0] q, output int unsigned qcyc);
    apply_stimulus(1'b0, i);
    qcyc = cyc;
    apply_stimulus(1'b1, q);
  endtask

  task automatic expect_one(string name, logic [23:0] exp_data, logic [1:0] exp_err,
                            int unsigned qcyc);
    out_rec_t r;
    check_output({name, "_count"}, outq.size(), 1);
    if (outq.size() > 0) begin
      r = outq.pop_front();
      check_output({name, "_data"}, r.data, exp_data);
      check_output({name, "_err"}, r.err, exp_err);
      check_output({name, "_lat"}, r.cyc - qcyc, 2);
    end
    outq.delete();
  endtask

  initial begin
    pair_vec_t      vecs[6];
    logic [23:0]    exp_decim_a[3];
    logic [23:0]    exp_decim_b[3];
    int unsigned    qc;
    int unsigned    qcs[3];
    logic [11:0]    nv;
    logic signed [11:0] yi;
    logic signed [11:0] yq;
    out_rec_t       r;

    vecs[0] = '{12'h123, 12'hABC, 24'h123ABC};
    vecs[1] = '{12'h000, 12'h000, 24'h000000};
    vecs[2] = '{12'h7FF, 12'h800, 24'h7FF800};
    vecs[3] = '{12'h800, 12'h7FF, 24'h8007FF};
    vecs[4] = '{12'hFFF, 12'h001, 24'hFFF001};
    vecs[5] = '{12'h5A5, 12'hA5A, 24'h5A5A5A};
    exp_decim_a = '{24'h000000, 24'h004FFC, 24'h008FF8};
    exp_decim_b = '{24'h00CFF4, 24'h00EFF2, 24'h010FF0};

    reset_reset_n = 1'b0;
    cfg_dc_en     = 1'b0;
    cfg_decim_m1  = 4'd0;
    bus.diq_valid = 1'b0;
    bus.diq_iqsel = 1'b0;
    bus.diq_data  = '0;

    idle(3);
    check_output("reset_data", bus.src_data, 24'h0);
    check_output("reset_valid", bus.src_valid, 1'b0);
    check_output("reset_error", bus.src_error, 2'b00);
    reset_reset_n = 1'b1;
    idle(2);

    $display("[TB] pairing, dc off, decim 1");
    for (int v = 0; v < 6; v++) begin
      send_pair(vecs[v].i, vecs[v].q, qc);
      idle(4);
      expect_one($sformatf("pair%0d", v), vecs[v].exp_data, 2'b00, qc);
    end

    $display("[TB] full-rate back-to-back pairs");
    send_pair(12'h111, 12'h222, qcs[0]);
    send_pair(12'h333, 12'h444, qcs[1]);
    send_pair(12'h555, 12'h666, qcs[2]);
    idle(4);
    check_output("b2b_count", outq.size(), 3);
    if (outq.size() == 3) begin
      check_output("b2b_d0", outq[0].data, 24'h111222);
      check_output("b2b_d1", outq[1].data, 24'h333444);
      check_output("b2b_d2", outq[2].data, 24'h555666);
      for (int k = 0; k < 3; k++) check_output($sformatf("b2b_lat%0d", k), outq[k].cyc - qcs[k], 2);
    end
    outq.delete();

    $display("[TB] misalignment");
    apply_stimulus(1'b0, 12'h005);
    send_pair(12'h007, 12'h009, qc);
    idle(4);
    expect_one("mis_ii", 24'h007009, 2'b01, qc);
    apply_stimulus(1'b1, 12'h055);
    idle(4);
    check_output("mis_lone_q_no_out", outq.size(), 0);
    send_pair(12'h001, 12'h002, qc);
    idle(4);
    expect_one("mis_lone_q_next", 24'h001002, 2'b01, qc);
    send_pair(12'h003, 12'h004, qc);
    idle(4);
    expect_one("mis_cleared", 24'h003004, 2'b00, qc);

    $display("[TB] decimation by 4, then ratio lowered mid-count");
    cfg_decim_m1 = 4'd3;
    for (int n = 0; n < 12; n++) begin
      nv = 12'(n);
      send_pair(nv, -nv, qc);
    end
    idle(4);
    check_output("dec4_count", outq.size(), 3);
    if (outq.size() == 3)
      for (int k = 0; k < 3; k++) check_output($sformatf("dec4_d%0d", k), outq[k].data, exp_decim_a[k]);
    outq.delete();
    for (int n = 12; n < 17; n++) begin
      if (n == 14) cfg_decim_m1 = 4'd1;
      nv = 12'(n);
      send_pair(nv, -nv, qc);
    end
    idle(4);
    check_output("dec_lower_count", outq.size(), 3);
    if (outq.size() == 3)
      for (int k = 0; k < 3; k++) check_output($sformatf("dec_lower_d%0d", k), outq[k].data, exp_decim_b[k]);
    outq.delete();
    cfg_decim_m1 = 4'd0;

    $display("[TB] dc removal, constant +400");
    cfg_dc_en = 1'b1;
    for (int n = 0; n < 8192; n++) send_pair(12'd400, 12'd400, qc);
    idle(4);
    check_output("dc_count", outq.size(), 8192);
    if (outq.size() > 0) begin
      check_output("dc_first", outq[0].data, 24'h190190);
      r  = outq[$];
      yi = r.data[23:12];
      yq = r.data[11:0];
      check_output("dc_conv_i", (yi >= -12'sd1 && yi <= 12'sd1), 1'b1);
      check_output("dc_conv_q", (yq >= -12'sd1 && yq <= 12'sd1), 1'b1);
      check_output("dc_err", r.err, 2'b00);
    end
    outq.delete();

    $display("[TB] dc removal, step to -2048");
    for (int n = 0; n < 3; n++) send_pair(12'h800, 12'h800, qc);
    idle(4);
    check_output("sat_count", outq.size(), 3);
    if (outq.size() == 3) begin
      for (int k = 0; k < 3; k++) check_output($sformatf("sat_d%0d", k), outq[k].data, 24'h800800);
      check_output("sat_err0", outq[0].err, 2'b00);
      check_output("sat_err1", outq[1].err, 2'b10);
      check_output("sat_err2", outq[2].err, 2'b10);
    end
    outq.delete();
    cfg_dc_en = 1'b0;

    $display("[TB] reset mid-stream");
    send_pair(12'h111, 12'h222, qc);
    bus.diq_valid = 1'b1;
    bus.diq_iqsel = 1'b0;
    bus.diq_data  = 12'h333;
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_output("rst_mid_data", bus.src_data, 24'h0);
    check_output("rst_mid_valid", bus.src_valid, 1'b0);
    check_output("rst_mid_error", bus.src_error, 2'b00);
    bus.diq_valid = 1'b0;
    idle(2);
    reset_reset_n = 1'b1;
    idle(2);
    check_output("rst_no_out", outq.size(), 0);
    apply_stimulus(1'b1, 12'h444);
    send_pair(12'h555, 12'h666, qc);
    idle(4);
    expect_one("rst_after", 24'h555666, 2'b01, qc);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
